// File: rtl/sram_par_pkg.sv
// Shared definitions for the parity-protected dual-port SRAM wrapper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sram_par_pkg;

   localparam int DATA_W_DEF = 36;
   localparam int DEPTH_DEF  = 512;
   localparam int ADDR_W_DEF = 9;
   localparam int CNT_W_DEF  = 8;

   // Widest word the parity helper accepts; callers zero-extend, which
   // leaves the XOR reduction unchanged.
   localparam int PAR_MAX_W = 64;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;

   typedef enum logic {
      COLL_NONE = 1'b0,
      COLL_WW   = 1'b1
   } coll_e;

   // Even parity: the bit that makes the total number of ones even.
   function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sram_dp_core.sv
// Behavioural true dual-port storage array, W bits x DEPTH words, no reset.
// Latency: combinational read of current contents; writes land on posedge.
//   The wrapper registers the read data, so a same-edge write is seen as
//   read-first (old data).
// Backpressure: none; every enabled write is accepted.
// Ports: clk; we_a/we_b write strobes; addr_a/addr_b word addresses;
//        wdat_a/wdat_b write words; rdat_a/rdat_b current array contents.
module sram_dp_core #(
   parameter int W      = 37,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [W-1:0]      wdat_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [W-1:0]      wdat_b,
   output logic [W-1:0]      rdat_a,
   output logic [W-1:0]      rdat_b
);

   logic [W-1:0] mem [DEPTH];

   // Port B is written first so that on a same-address double write the
   // later non-blocking update from port A is the one that sticks.
   always_ff @(posedge clk) begin
      if (we_b) mem[addr_b] <= wdat_b;
      if (we_a) mem[addr_a] <= wdat_a;
   end

   assign rdat_a = mem[addr_a];
   assign rdat_b = mem[addr_b];

endmodule

// File: rtl/sram_dp_par_wrap.sv
// Dual-port SRAM wrapper with per-word even parity, error logging, write-write
//   collision flag, parity injection on port A and scan-mode output clamp.
// Latency: read data and perr one cycle after the read edge; log one cycle later.
// Backpressure: none; accesses are accepted every cycle unless scan_mode blocks them.
// Ports: CLK, reset_n (async, active low), scan_mode; MEx/WEx/ADRx/DX request
//   per port; QX read data; par_inj, err_clr; perr_x, err_sticky, err_cnt,
//   err_addr, err_port error log; collision pulse.
module sram_dp_par_wrap
   import sram_par_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              reset_n,
   input  logic              scan_mode,
   input  logic              MEA,
   input  logic              MEB,
   input  logic              WEA,
   input  logic              WEB,
   input  logic [ADDR_W-1:0] ADRA,
   input  logic [ADDR_W-1:0] ADRB,
   input  logic [DATA_W-1:0] DA,
   input  logic [DATA_W-1:0] DB,
   output logic [DATA_W-1:0] QA,
   output logic [DATA_W-1:0] QB,
   input  logic              par_inj,
   input  logic              err_clr,
   output logic              perr_a,
   output logic              perr_b,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_port,
   output logic              collision
);

   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

   logic              a_ok, b_ok, me_a_eff, me_b_eff;
   logic              wr_a, wr_b, rd_a, rd_b;
   logic [DATA_W:0]   wdat_a, wdat_b, rdat_a, rdat_b;

   logic [DATA_W-1:0] qa_q, qa_d, qb_q, qb_d;
   logic              pa_q, pa_d, pb_q, pb_d;
   logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              port_q, port_d;
   logic              coll_q, coll_d;

   logic              sticky_base;
   logic [CNT_W-1:0]  cnt_base;
   logic [CNT_W+1:0]  cnt_sum;

   // Out-of-range addresses never touch the array.
   assign a_ok     = {1'b0, ADRA} < DEPTH_L;
   assign b_ok     = {1'b0, ADRB} < DEPTH_L;
   assign me_a_eff = MEA & ~scan_mode;
   assign me_b_eff = MEB & ~scan_mode;
   assign wr_a     = me_a_eff & WEA & a_ok;
   assign wr_b     = me_b_eff & WEB & b_ok;
   assign rd_a     = me_a_eff & ~WEA;
   assign rd_b     = me_b_eff & ~WEB;

   assign wdat_a = {even_par(PAR_MAX_W'(DA)) ^ par_inj, DA};
   assign wdat_b = {even_par(PAR_MAX_W'(DB)), DB};

   sram_dp_core #(
      .W      (DATA_W + 1),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk    (CLK),
      .we_a   (wr_a),
      .addr_a (ADRA),
      .wdat_a (wdat_a),
      .we_b   (wr_b),
      .addr_b (ADRB),
      .wdat_b (wdat_b),
      .rdat_a (rdat_a),
      .rdat_b (rdat_b)
   );

   // Read capture: Q holds until the next read; perr lives for one cycle.
   // A stored word with odd total parity is a parity error.
   always_comb begin
      qa_d = qa_q;
      qb_d = qb_q;
      pa_d = 1'b0;
      pb_d = 1'b0;
      ra_d = ra_q;
      rb_d = rb_q;
      if (rd_a) begin
         ra_d = ADRA;
         qa_d = a_ok ? rdat_a[DATA_W-1:0] : '0;
         pa_d = a_ok & even_par(PAR_MAX_W'(rdat_a));
      end
      if (rd_b) begin
         rb_d = ADRB;
         qb_d = b_ok ? rdat_b[DATA_W-1:0] : '0;
         pb_d = b_ok & even_par(PAR_MAX_W'(rdat_b));
      end
   end

   assign perr_a = pa_q & ~scan_mode;
   assign perr_b = pb_q & ~scan_mode;

   // Error log. A clear and a new error on the same edge: clear first, then
   // log the new error on top, so the new error survives the clear.
   always_comb begin
      sticky_base = err_clr ? 1'b0 : sticky_q;
      cnt_base    = err_clr ? '0 : cnt_q;
      addr_d      = err_clr ? '0 : addr_q;
      port_d      = err_clr ? 1'b0 : port_q;
      cnt_sum     = {2'b00, cnt_base} + (CNT_W+2)'(perr_a) + (CNT_W+2)'(perr_b);
      cnt_d       = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
      sticky_d    = sticky_base | perr_a | perr_b;
      if (!sticky_base && (perr_a || perr_b)) begin
         addr_d = perr_a ? ra_q : rb_q;
         port_d = perr_a ? PORT_A : PORT_B;
      end
      coll_d = (wr_a && wr_b && (ADRA == ADRB)) ? COLL_WW : COLL_NONE;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         qa_q     <= '0;
         qb_q     <= '0;
         pa_q     <= 1'b0;
         pb_q     <= 1'b0;
         ra_q     <= '0;
         rb_q     <= '0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
         addr_q   <= '0;
         port_q   <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         qa_q     <= qa_d;
         qb_q     <= qb_d;
         pa_q     <= pa_d;
         pb_q     <= pb_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         port_q   <= port_d;
         coll_q   <= coll_d;
      end
   end

   // Scan clamps the outputs only; the held read data reappears afterwards.
   assign QA         = scan_mode ? '0 : qa_q;
   assign QB         = scan_mode ? '0 : qb_q;
   assign err_sticky = sticky_q;
   assign err_cnt    = cnt_q;
   assign err_addr   = addr_q;
   assign err_port   = port_q;
   assign collision  = coll_q;

endmodule

// File: tb/tb_sram_dp_par_wrap.sv
// Bench for sram_dp_par_wrap: vector table plus read-data scoreboard, and a
//   reset-during-read sequence. A second instance with a 2-bit counter sees
//   the same stimulus to exercise counter saturation.
module tb_sram_dp_par_wrap;

   localparam int DW = 36;
   localparam int AW = 9;

   logic          CLK = 1'b0;
   logic          reset_n, scan_mode, MEA, MEB, WEA, WEB, par_inj, err_clr;
   logic [AW-1:0] ADRA, ADRB;
   logic [DW-1:0] DA, DB;
   logic [DW-1:0] QA, QB, QA2, QB2;
   logic          perr_a, perr_b, err_sticky, err_port, collision;
   logic          perr_a2, perr_b2, err_sticky2, err_port2, collision2;
   logic [7:0]    err_cnt;
   logic [1:0]    err_cnt2;
   logic [AW-1:0] err_addr, err_addr2;

   always #5 CLK = ~CLK;

   sram_dp_par_wrap #(.DATA_W(DW), .DEPTH(512), .ADDR_W(AW), .CNT_W(8)) dut (
      .CLK(CLK), .reset_n(reset_n), .scan_mode(scan_mode),
      .MEA(MEA), .MEB(MEB), .WEA(WEA), .WEB(WEB),
      .ADRA(ADRA), .ADRB(ADRB), .DA(DA), .DB(DB), .QA(QA), .QB(QB),
      .par_inj(par_inj), .err_clr(err_clr), .perr_a(perr_a), .perr_b(perr_b),
      .err_sticky(err_sticky), .err_cnt(err_cnt), .err_addr(err_addr),
      .err_port(err_port), .collision(collision)
   );

   sram_dp_par_wrap #(.DATA_W(DW), .DEPTH(512), .ADDR_W(AW), .CNT_W(2)) dut2 (
      .CLK(CLK), .reset_n(reset_n), .scan_mode(scan_mode),
      .MEA(MEA), .MEB(MEB), .WEA(WEA), .WEB(WEB),
      .ADRA(ADRA), .ADRB(ADRB), .DA(DA), .DB(DB), .QA(QA2), .QB(QB2),
      .par_inj(par_inj), .err_clr(err_clr), .perr_a(perr_a2), .perr_b(perr_b2),
      .err_sticky(err_sticky2), .err_cnt(err_cnt2), .err_addr(err_addr2),
      .err_port(err_port2), .collision(collision2)
   );

   typedef struct {
      logic          scan, mea, wea, meb, web, inj, clr;
      logic [AW-1:0] adra, adrb;
      logic [DW-1:0] da, db;
      logic          e_coll, e_sticky, e_port;
      logic [7:0]    e_cnt;
      logic [AW-1:0] e_addr;
      logic [1:0]    e_cnt2;
   } vec_t;

   typedef struct {
      logic          port;
      logic [DW-1:0] dat;
      logic          perr;
   } sb_t;

   sb_t           sb_q[$];
   logic [DW:0]   mdl [int];
   logic [DW-1:0] hold_a, hold_b;
   int            checks = 0;
   int            errors = 0;
   vec_t          vt [25];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input int s, input int ma, input int wa, input int aa,
                               input logic [DW-1:0] d_a, input int mb, input int wb,
                               input int ab, input logic [DW-1:0] d_b, input int inj,
                               input int clr, input int coll, input int st, input int cnt,
                               input int ea, input int ep, input int cnt2);
      vec_t v;
      v.scan = s[0];   v.mea = ma[0];  v.wea = wa[0];  v.adra = aa[AW-1:0]; v.da = d_a;
      v.meb = mb[0];   v.web = wb[0];  v.adrb = ab[AW-1:0]; v.db = d_b;
      v.inj = inj[0];  v.clr = clr[0];
      v.e_coll = coll[0]; v.e_sticky = st[0]; v.e_cnt = cnt[7:0];
      v.e_addr = ea[AW-1:0]; v.e_port = ep[0]; v.e_cnt2 = cnt2[1:0];
      return v;
   endfunction

   task automatic idle_inputs();
      scan_mode = 1'b0; MEA = 1'b0; WEA = 1'b0; MEB = 1'b0; WEB = 1'b0;
      ADRA = '0; ADRB = '0; DA = '0; DB = '0; par_inj = 1'b0; err_clr = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      sb_t         e;
      bit          seen_a, seen_b;
      logic [DW:0] w;
      scan_mode = v.scan; MEA = v.mea; WEA = v.wea; ADRA = v.adra; DA = v.da;
      MEB = v.meb; WEB = v.web; ADRB = v.adrb; DB = v.db;
      par_inj = v.inj; err_clr = v.clr;
      // Reads see the array before this edge's writes.
      if (v.mea && !v.scan && !v.wea) begin
         w = mdl[int'(v.adra)];
         e.port = 1'b0; e.dat = w[DW-1:0]; e.perr = ^w;
         sb_q.push_back(e);
      end
      if (v.meb && !v.scan && !v.web) begin
         w = mdl[int'(v.adrb)];
         e.port = 1'b1; e.dat = w[DW-1:0]; e.perr = ^w;
         sb_q.push_back(e);
      end
      if (v.meb && !v.scan && v.web) mdl[int'(v.adrb)] = {^v.db, v.db};
      if (v.mea && !v.scan && v.wea) mdl[int'(v.adra)] = {(^v.da) ^ v.inj, v.da};
      @(posedge CLK);
      #1;
      seen_a = 1'b0;
      seen_b = 1'b0;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         if (e.port == 1'b0) begin
            seen_a = 1'b1; hold_a = e.dat;
            chk($sformatf("r%0d_QA", idx), 64'(QA), 64'(e.dat));
            chk($sformatf("r%0d_perr_a", idx), 64'(perr_a), 64'(e.perr));
         end else begin
            seen_b = 1'b1; hold_b = e.dat;
            chk($sformatf("r%0d_QB", idx), 64'(QB), 64'(e.dat));
            chk($sformatf("r%0d_perr_b", idx), 64'(perr_b), 64'(e.perr));
         end
      end
      if (!seen_a) begin
         chk($sformatf("r%0d_QA_hold", idx), 64'(QA), v.scan ? 64'd0 : 64'(hold_a));
         chk($sformatf("r%0d_perr_a_idle", idx), 64'(perr_a), 64'd0);
      end
      if (!seen_b) begin
         chk($sformatf("r%0d_QB_hold", idx), 64'(QB), v.scan ? 64'd0 : 64'(hold_b));
         chk($sformatf("r%0d_perr_b_idle", idx), 64'(perr_b), 64'd0);
      end
      chk($sformatf("r%0d_collision", idx), 64'(collision), 64'(v.e_coll));
      chk($sformatf("r%0d_err_sticky", idx), 64'(err_sticky), 64'(v.e_sticky));
      chk($sformatf("r%0d_err_cnt", idx), 64'(err_cnt), 64'(v.e_cnt));
      chk($sformatf("r%0d_err_addr", idx), 64'(err_addr), 64'(v.e_addr));
      chk($sformatf("r%0d_err_port", idx), 64'(err_port), 64'(v.e_port));
      chk($sformatf("r%0d_err_cnt_w2", idx), 64'(err_cnt2), 64'(v.e_cnt2));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_QA"}, 64'(QA), 64'd0);
      chk({tag, "_QB"}, 64'(QB), 64'd0);
      chk({tag, "_perr_a"}, 64'(perr_a), 64'd0);
      chk({tag, "_perr_b"}, 64'(perr_b), 64'd0);
      chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
      chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
      chk({tag, "_err_addr"}, 64'(err_addr), 64'd0);
      chk({tag, "_err_port"}, 64'(err_port), 64'd0);
      chk({tag, "_collision"}, 64'(collision), 64'd0);
      chk({tag, "_err_cnt_w2"}, 64'(err_cnt2), 64'd0);
      chk({tag, "_err_sticky_w2"}, 64'(err_sticky2), 64'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      //               scan mea wea adra  da              meb web adrb  db            inj clr  coll st cnt addr  port cnt2
      vt[0]  = mk(0, 1,1,'h005, 36'h912345678, 0,0,'h000, 36'h0,   0,0,  0,0,0,'h000,0,0);
      vt[1]  = mk(0, 0,0,'h000, 36'h0,         1,0,'h005, 36'h0,   0,0,  0,0,0,'h000,0,0);
      vt[2]  = mk(0, 1,1,'h010, 36'h0FF,       0,0,'h000, 36'h0,   1,0,  0,0,0,'h000,0,0);
      vt[3]  = mk(0, 1,0,'h010, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,0,0,'h000,0,0);
      vt[4]  = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,1,'h010,0,1);
      vt[5]  = mk(0, 1,1,'h020, 36'hAAA,       1,1,'h020, 36'h555, 0,0,  1,1,1,'h010,0,1);
      vt[6]  = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,1,'h010,0,1);
      vt[7]  = mk(0, 1,0,'h020, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,1,'h010,0,1);
      vt[8]  = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,1,  0,0,0,'h000,0,0);
      vt[9]  = mk(0, 1,1,'h030, 36'h123,       0,0,'h000, 36'h0,   1,0,  0,0,0,'h000,0,0);
      vt[10] = mk(0, 1,1,'h031, 36'h456,       0,0,'h000, 36'h0,   1,0,  0,0,0,'h000,0,0);
      vt[11] = mk(0, 1,0,'h030, 36'h0,         1,0,'h031, 36'h0,   0,0,  0,0,0,'h000,0,0);
      vt[12] = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,2,'h030,0,2);
      vt[13] = mk(0, 1,0,'h030, 36'h0,         1,0,'h031, 36'h0,   0,0,  0,1,2,'h030,0,2);
      vt[14] = mk(0, 1,0,'h010, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,4,'h030,0,3);
      vt[15] = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,5,'h030,0,3);
      vt[16] = mk(0, 1,0,'h010, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,5,'h030,0,3);
      vt[17] = mk(1, 1,0,'h005, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,5,'h030,0,3);
      vt[18] = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,5,'h030,0,3);
      vt[19] = mk(0, 1,1,'h040, 36'h7,         0,0,'h000, 36'h0,   1,0,  0,1,5,'h030,0,3);
      vt[20] = mk(0, 0,0,'h000, 36'h0,         1,0,'h040, 36'h0,   0,0,  0,1,5,'h030,0,3);
      vt[21] = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,1,  0,1,1,'h040,1,1);
      vt[22] = mk(0, 0,0,'h000, 36'h0,         0,0,'h000, 36'h0,   0,0,  0,1,1,'h040,1,1);
      vt[23] = mk(0, 1,1,'h005, 36'h111,       1,0,'h005, 36'h0,   0,0,  0,1,1,'h040,1,1);
      vt[24] = mk(0, 0,0,'h000, 36'h0,         1,0,'h005, 36'h0,   0,0,  0,1,1,'h040,1,1);

      hold_a = '0;
      hold_b = '0;
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge CLK);
      #1;
      chk_all_zero("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 25; i++) run_vec(vt[i], i);

      // Reset asserted while reads are in flight: the reads are dropped.
      MEA = 1'b1; WEA = 1'b0; ADRA = 9'h020;
      MEB = 1'b1; WEB = 1'b0; ADRB = 9'h040;
      #2;
      reset_n = 1'b0;
      @(posedge CLK);
      #1;
      chk_all_zero("midreset");
      idle_inputs();
      reset_n = 1'b1;
      hold_a = '0;
      hold_b = '0;
      sb_q.delete();

      // Array contents survive the reset.
      run_vec(mk(0, 1,0,'h005, 36'h0, 1,0,'h020, 36'h0, 0,0, 0,0,0,'h000,0,0), 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
